// File: rtl/ftoi_pipe.sv
// Two-stage pipelined float32 -> int32 converter with rounding, saturation and
// NaN handling, valid/ready handshaked on both sides (capacity 2 operands).
module ftoi_pipe #(
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf
);

    localparam logic [2:0] CLS_RSH    = 3'd0;
    localparam logic [2:0] CLS_LSH    = 3'd1;
    localparam logic [2:0] CLS_MINNEG = 3'd2;
    localparam logic [2:0] CLS_SAT    = 3'd3;
    localparam logic [2:0] CLS_NAN    = 3'd4;

    logic        adv1, adv2;

    logic        s1_valid;
    logic        s1_sign;
    logic [2:0]  s1_cls;
    logic [4:0]  s1_rsh;
    logic [2:0]  s1_lsh;
    logic [23:0] s1_mant;

    logic [7:0]  x_exp;
    logic [22:0] x_man;
    logic [2:0]  d_cls;
    logic [4:0]  d_rsh;
    logic [2:0]  d_lsh;

    logic [24:0] rsh_ext;
    logic [31:0] mag;
    logic [31:0] d_y;
    logic        d_ovf;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    assign x_exp = x[30:23];
    assign x_man = x[22:0];

    // Everything below e=150 (zero, denormal, sub-half, half) goes through the
    // right-shift path; a clamped shift of 25 yields a zero magnitude and guard.
    always_comb begin
        d_cls = CLS_RSH;
        d_rsh = '0;
        d_lsh = '0;
        if (x_exp == 8'hFF && x_man != '0) begin
            d_cls = CLS_NAN;
        end else if (x_exp >= 8'd158) begin
            d_cls = (x_exp == 8'd158 && x[31] && x_man == '0) ? CLS_MINNEG : CLS_SAT;
        end else if (x_exp >= 8'd150) begin
            d_cls = CLS_LSH;
            d_lsh = 3'(x_exp - 8'd150);
        end else begin
            d_cls = CLS_RSH;
            d_rsh = (x_exp < 8'd125) ? 5'd25 : 5'(8'd150 - x_exp);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls   <= CLS_RSH;
            s1_rsh   <= '0;
            s1_lsh   <= '0;
            s1_mant  <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= x[31];
                s1_cls  <= d_cls;
                s1_rsh  <= d_rsh;
                s1_lsh  <= d_lsh;
                s1_mant <= {x_exp != 8'd0, x_man};
            end
        end
    end

    // Bit 0 of the extended shift result is the guard bit just below the LSB.
    assign rsh_ext = {s1_mant, 1'b0} >> s1_rsh;

    always_comb begin
        mag   = '0;
        d_y   = '0;
        d_ovf = 1'b0;
        case (s1_cls)
            CLS_RSH: begin
                mag = {8'd0, rsh_ext[24:1]} + 32'(ROUND_NEAREST & rsh_ext[0]);
                d_y = s1_sign ? (~mag + 32'd1) : mag;
            end
            CLS_LSH: begin
                mag = {8'd0, s1_mant} << s1_lsh;
                d_y = s1_sign ? (~mag + 32'd1) : mag;
            end
            CLS_MINNEG: begin
                d_y = 32'h8000_0000;
            end
            CLS_SAT: begin
                d_y   = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                d_ovf = 1'b1;
            end
            CLS_NAN: begin
                d_y   = 32'h7FFF_FFFF;
                d_ovf = 1'b1;
            end
            default: begin
                d_y   = '0;
                d_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y   <= d_y;
                ovf <= d_ovf;
            end
        end
    end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: both rounding modes side by side, directed cases,
// backpressure, mid-flight reset and a randomized handshake stream vs a real-arithmetic model.
module tb_ftoi_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] x;

    logic        in_ready1, out_valid1, ovf1;
    logic [31:0] y1;
    logic        in_ready0, out_valid0, ovf0;
    logic [31:0] y0;

    int checks = 0;
    int errors = 0;

    logic [32:0] q1[$];
    logic [32:0] q0[$];

    logic [31:0] sp [12] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                             32'h7FC0_0000, 32'hCF00_0000, 32'h4F00_0000, 32'h3F00_0000,
                             32'hBF00_0000, 32'h4EFF_FFFF, 32'hCEFF_FFFF, 32'h0000_0001};

    always #5 clk = ~clk;

    ftoi_pipe #(.ROUND_NEAREST(1'b1)) dut_rn (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready1), .x(x),
        .out_valid(out_valid1), .out_ready(out_ready), .y(y1), .ovf(ovf1)
    );

    ftoi_pipe #(.ROUND_NEAREST(1'b0)) dut_tr (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready0), .x(x),
        .out_valid(out_valid0), .out_ready(out_ready), .y(y0), .ovf(ovf0)
    );

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else repeat (-k) r = r / 2.0;
        return r;
    endfunction

    // Returns {ovf, y}: value of the float by plain arithmetic, then rounded and clipped.
    function automatic logic [32:0] model(input logic [31:0] v, input bit rn);
        int     e, m;
        real    a, mag;
        longint li;
        e = int'(v[30:23]);
        m = int'(v[22:0]);
        if (e == 255 && m != 0) return {1'b1, 32'h7FFF_FFFF};
        if (e == 0) a = real'(m) * pow2(-149);
        else        a = (real'(m) + 8388608.0) * pow2(e - 150);
        mag = rn ? $floor(a + 0.5) : $floor(a);
        if (v[31]) begin
            if (mag > 2147483648.0) return {1'b1, 32'h8000_0000};
        end else if (mag > 2147483647.0) begin
            return {1'b1, 32'h7FFF_FFFF};
        end
        li = longint'(mag);
        if (v[31]) li = -li;
        return {1'b0, li[31:0]};
    endfunction

    task automatic lat(input logic [31:0] xv, input logic [32:0] e1, input logic [32:0] e0);
        @(negedge clk);
        in_valid = 1'b1; x = xv; out_ready = 1'b1;
        #1 chk($sformatf("lat_in_ready_%h", xv), {32'd0, in_ready1}, 33'd1);
        @(negedge clk);
        in_valid = 1'b0; x = $urandom;
        #1;
        chk($sformatf("lat_c1_valid_rn_%h", xv), {32'd0, out_valid1}, 33'd0);
        chk($sformatf("lat_c1_valid_tr_%h", xv), {32'd0, out_valid0}, 33'd0);
        @(negedge clk);
        #1;
        chk($sformatf("lat_c2_valid_rn_%h", xv), {32'd0, out_valid1}, 33'd1);
        chk($sformatf("lat_c2_valid_tr_%h", xv), {32'd0, out_valid0}, 33'd1);
        chk($sformatf("lat_res_rn_%h", xv), {ovf1, y1}, e1);
        chk($sformatf("lat_res_tr_%h", xv), {ovf0, y0}, e0);
    endtask

    initial begin
        logic [31:0] bp_vals [4];
        int          sent, recv, got_cnt;
        logic [31:0] got_val;
        logic [31:0] xv;
        logic [7:0]  ev;
        logic        hold, stall1, stall0;
        logic [32:0] prev1, prev0, exp_v;

        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid_rn", {32'd0, out_valid1}, 33'd0);
        chk("rst_out_valid_tr", {32'd0, out_valid0}, 33'd0);
        chk("rst_y_ovf_rn", {ovf1, y1}, 33'd0);
        chk("rst_y_ovf_tr", {ovf0, y0}, 33'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed conversions: {ovf, y} for round-nearest and truncate.
        lat(32'h4020_0000, {1'b0, 32'h0000_0003}, {1'b0, 32'h0000_0002});
        lat(32'hC020_0000, {1'b0, 32'hFFFF_FFFD}, {1'b0, 32'hFFFF_FFFE});
        lat(32'h3F00_0000, {1'b0, 32'h0000_0001}, {1'b0, 32'h0000_0000});
        lat(32'h3EFF_FFFF, {1'b0, 32'h0000_0000}, {1'b0, 32'h0000_0000});
        lat(32'hBFFF_FFFF, {1'b0, 32'hFFFF_FFFE}, {1'b0, 32'hFFFF_FFFF});
        lat(32'h3FC0_0000, {1'b0, 32'h0000_0002}, {1'b0, 32'h0000_0001});
        lat(32'hBF00_0000, {1'b0, 32'hFFFF_FFFF}, {1'b0, 32'h0000_0000});
        lat(32'h4EFF_FFFF, {1'b0, 32'h7FFF_FF80}, {1'b0, 32'h7FFF_FF80});
        lat(32'h4F00_0000, {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h7FFF_FFFF});
        lat(32'hCF00_0000, {1'b0, 32'h8000_0000}, {1'b0, 32'h8000_0000});
        lat(32'hCF00_0001, {1'b1, 32'h8000_0000}, {1'b1, 32'h8000_0000});
        lat(32'h7FC0_0000, {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h7FFF_FFFF});
        lat(32'hFFC0_0000, {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h7FFF_FFFF});
        lat(32'h8000_0000, {1'b0, 32'h0000_0000}, {1'b0, 32'h0000_0000});
        lat(32'hFF80_0000, {1'b1, 32'h8000_0000}, {1'b1, 32'h8000_0000});

        // Backpressure: 1.0..4.0 back-to-back, consumer stalled for cycles 0-5.
        bp_vals[0] = 32'h3F80_0000; bp_vals[1] = 32'h4000_0000;
        bp_vals[2] = 32'h4040_0000; bp_vals[3] = 32'h4080_0000;
        sent = 0; recv = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc >= 6);
            in_valid  = (sent < 4);
            x         = bp_vals[sent < 4 ? sent : 3];
            #1;
            if (cyc < 6)
                chk($sformatf("bp_in_ready_c%0d", cyc), {32'd0, in_ready1}, {32'd0, (cyc < 2) ? 1'b1 : 1'b0});
            if (cyc >= 2 && cyc < 6) begin
                chk($sformatf("bp_hold_rn_c%0d", cyc), {out_valid1, y1}, {1'b1, 32'd1});
                chk($sformatf("bp_hold_tr_c%0d", cyc), {out_valid0, y0}, {1'b1, 32'd1});
            end
            if (cyc >= 6 && cyc < 10)
                chk($sformatf("bp_stream_valid_c%0d", cyc), {32'd0, out_valid1}, 33'd1);
            if (out_valid1 && out_ready) begin
                chk($sformatf("bp_order_rn_%0d", recv), {ovf1, y1}, {1'b0, 32'(recv + 1)});
                chk($sformatf("bp_order_tr_%0d", recv), {ovf0, y0}, {1'b0, 32'(recv + 1)});
                recv++;
            end
            if (in_valid && in_ready1) sent++;
            @(negedge clk);
        end
        chk("bp_recv_count", 33'(recv), 33'd4);

        // Reset while two operands are in flight.
        out_ready = 1'b0; in_valid = 1'b1; x = 32'h40A0_0000;
        @(negedge clk);
        x = 32'h40C0_0000;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_rn", {out_valid1, ovf1, y1}, 34'd0);
        chk("rst_mid_tr", {out_valid0, ovf0, y0}, 34'd0);
        @(negedge clk);
        rstn = 1'b1; in_valid = 1'b1; x = 32'h40E0_0000; out_ready = 1'b1;
        got_cnt = 0; got_val = '0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            if (out_valid1 && out_ready) begin
                got_cnt++;
                got_val = y1;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("rst_after_count", 33'(got_cnt), 33'd1);
        chk("rst_after_value", {1'b0, got_val}, 33'd7);

        // Random stream with random handshakes on both sides.
        hold = 1'b0; stall1 = 1'b0; stall0 = 1'b0; prev1 = '0; prev0 = '0; xv = '0;
        for (int n = 0; n < 12000; n++) begin
            @(negedge clk);
            if (!hold) begin
                case ($urandom_range(0, 3))
                    0: xv = $urandom;
                    1: begin ev = 8'($urandom_range(120, 160)); xv = {1'($urandom), ev, 23'($urandom)}; end
                    2: begin ev = 8'($urandom_range(140, 159)); xv = {1'($urandom), ev, 23'($urandom)}; end
                    default: xv = sp[$urandom_range(0, 11)];
                endcase
                in_valid = ($urandom_range(0, 3) != 0);
            end
            x = xv;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (stall1) chk("rnd_stall_hold_rn", {ovf1, y1}, prev1);
            if (stall0) chk("rnd_stall_hold_tr", {ovf0, y0}, prev0);
            if (out_valid1 && out_ready) begin
                checks++;
                assert (q1.size() > 0) else begin
                    errors++;
                    $error("FAIL rnd_extra_rn observed=%h expected=none", y1);
                end
                if (q1.size() > 0) begin
                    exp_v = q1.pop_front();
                    chk("rnd_rn", {ovf1, y1}, exp_v);
                end
            end
            if (out_valid0 && out_ready) begin
                checks++;
                assert (q0.size() > 0) else begin
                    errors++;
                    $error("FAIL rnd_extra_tr observed=%h expected=none", y0);
                end
                if (q0.size() > 0) begin
                    exp_v = q0.pop_front();
                    chk("rnd_tr", {ovf0, y0}, exp_v);
                end
            end
            if (in_valid && in_ready1) q1.push_back(model(x, 1'b1));
            if (in_valid && in_ready0) q0.push_back(model(x, 1'b0));
            hold   = in_valid && !in_ready1;
            stall1 = out_valid1 && !out_ready;
            stall0 = out_valid0 && !out_ready;
            prev1  = {ovf1, y1};
            prev0  = {ovf0, y0};
        end

        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (out_valid1 && q1.size() > 0) begin
                exp_v = q1.pop_front();
                chk("drain_rn", {ovf1, y1}, exp_v);
            end
            if (out_valid0 && q0.size() > 0) begin
                exp_v = q0.pop_front();
                chk("drain_tr", {ovf0, y0}, exp_v);
            end
            @(negedge clk);
        end
        chk("drain_empty_rn", 33'(q1.size()), 33'd0);
        chk("drain_empty_tr", 33'(q0.size()), 33'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
Two-stage pipelined IEEE-754 single-precision to signed 32-bit integer converter, consuming the output of the FPU floor stage (ftoi/floor path of the CPU's FPU). Applies rounding, saturation and NaN handling. Uses a valid/ready handshake on both sides, so the core can stall it without losing results.

Parameters:
ROUND_NEAREST, 1, 1 = round half away from zero; 0 = truncate toward zero

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  x is valid this cycle
in_ready  output  1  stage can accept x this cycle
x  input  32  float operand {s, e[7:0], m[22:0]}
out_valid  output  1  y/ovf valid
out_ready  input  1  consumer accepts y this cycle
y  output  32  two's-complement integer result
ovf  output  1  result saturated (overflow or NaN/Inf)

Behaviour:
- Reset (rstn=0, asynchronous): s1_valid=0, out_valid=0, y=0, ovf=0. Any in-flight operands are discarded. First accept is possible on the first rising edge after release.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stage 2 (output regs) advance: adv2 = !out_valid || out_ready.
- Stage 1 advance: adv1 = !s1_valid || adv2.
- in_ready = adv1, combinational from out_ready. No combinational path from in_valid to outputs.
- Latency: exactly 2 cycles from accept to out_valid when there is no stall. Throughput is 1/cycle. Capacity is 2 operands.
- While stalled (out_valid && !out_ready), y, ovf and out_valid hold stable.
- Ordering is strictly FIFO.
- Stage 1 registers: s; shift class; left shift amount (e-150, when e>=150) or right shift amount (150-e, when e<150, clamped to 25); mant24 = {e!=0, m}; special flags.
- Stage 2: compute the magnitude, round, negate if s, saturate, register y/ovf.
- Classification:
  - e=0 (zero/denormal) → y=0, ovf=0.
  - e<126 → y=0 in both modes.
  - e=126 (0.5 ≤ |x| < 1) → ±1 if ROUND_NEAREST, else 0.
  - 127 ≤ e ≤ 149: mag = mant24 >> (150-e). guard = bit shifted out just below the LSB. If ROUND_NEAREST, mag += guard.
  - 150 ≤ e ≤ 157: mag = mant24 << (e-150), exact, no rounding.
  - e=158, s=1, m=0 → y=0x80000000, ovf=0.
  - Otherwise, for e ≥ 158: y = s ? 0x80000000 : 0x7FFFFFFF, ovf=1.
  - NaN (e=255, m≠0) → y=0x7FFFFFFF, ovf=1, sign ignored.
- Negation: y = s ? (~mag + 1) : mag. A zero magnitude gives y=0 (no 0x80000000 from -0).
- Width rules: mag is held in 32 bits. The maximum non-saturating magnitude is 2^31-128 (e=157), so no rounding carry can reach bit 31.
- Simultaneous accept and emit in one cycle: both occur and are valid.
- in_valid while in_ready=0: the operand is not taken. The upstream stage must hold x.

Test Plan:
- ROUND_NEAREST=1: x=0x40200000 (2.5) → y=3. x=0xC0200000 (-2.5) → y=0xFFFFFFFD. x=0x3F000000 (0.5) → y=1. x=0x3EFFFFFF → y=0. All with ovf=0, out_valid exactly 2 cycles after accept.
- ROUND_NEAREST=0: x=0x40200000 → y=2. x=0xBFFFFFFF (-1.99999) → y=0xFFFFFFFF. x=0x4EFFFFFF → y=0x7FFFFF80.
- Saturation: x=0x4F000000 → y=0x7FFFFFFF, ovf=1. x=0xCF000000 → y=0x80000000, ovf=0. x=0xCF000001 → y=0x80000000, ovf=1. x=0x7FC00000 → y=0x7FFFFFFF, ovf=1. x=0x80000000 → y=0.
- Backpressure: send 1.0, 2.0, 3.0, 4.0 back-to-back with out_ready=0 for cycles 0–5:
  - in_ready must fall after 2 accepts.
  - y holds 1 while stalled.
  - After out_ready=1, outputs are 1, 2, 3, 4 in order, one per cycle, with no duplicates or drops.
- Reset mid-operation: accept 2 operands, assert rstn=0 between clock edges → out_valid=0, y=0 immediately. After release, only new operands appear at the output.
- Random stream (≥10k vectors, random in_valid/out_ready) checked against a reference model for both parameter values.
